// File: rtl/axis_packet_sink.sv
// AXI4-Stream slave sink: programmable backpressure, packet framing, running
// statistics, per-packet length/tuser capture and sticky protocol-error flags.
module axis_packet_sink #(
  parameter int MAX_PKT_BYTES = 9216,
  parameter int CNT_W         = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [511:0]     s_axis_tdata,
  input  logic [63:0]      s_axis_tkeep,
  input  logic             s_axis_tlast,
  input  logic [63:0]      s_axis_tuser,
  input  logic [3:0]       throttle,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] beat_count,
  output logic [47:0]      byte_count,
  output logic [15:0]      last_pkt_len,
  output logic [63:0]      last_pkt_user,
  output logic             pkt_done,
  output logic             in_packet,
  output logic             err_keep,
  output logic             err_len,
  output logic             err_user
);

  typedef enum logic {IDLE, IN_PKT} state_e;

  state_e           state_q;
  logic [3:0]       ctr_q;
  logic             tready_q;
  logic [15:0]      cur_len_q;
  logic [63:0]      first_user_q;
  logic [CNT_W-1:0] pkt_count_q, beat_count_q;
  logic [47:0]      byte_count_q;
  logic [15:0]      last_len_q;
  logic [63:0]      last_user_q;
  logic             pkt_done_q;
  logic             err_keep_q, err_len_q, err_user_q;

  logic        accept;
  logic [6:0]  pop_d;
  logic [16:0] len_sum;
  logic [15:0] len_d;
  logic        keep_bad, len_bad, user_bad;

  // Payload is never inspected; reducing it keeps the port visibly consumed.
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata;

  assign accept = s_axis_tvalid & tready_q;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < 64; i++) pop_d = pop_d + 7'(s_axis_tkeep[i]);
  end

  // A first beat starts the length from zero; the sum saturates at 16 bits.
  assign len_sum  = {1'b0, (state_q == IN_PKT) ? cur_len_q : 16'd0} + 17'(pop_d);
  assign len_d    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  assign len_bad  = len_sum > 17'(MAX_PKT_BYTES);
  assign keep_bad = (s_axis_tkeep == '0)
                  || ((s_axis_tkeep & (s_axis_tkeep + 64'd1)) != '0)
                  || (!s_axis_tlast && (s_axis_tkeep != '1));
  assign user_bad = (state_q == IN_PKT) && (s_axis_tuser != first_user_q);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      ctr_q        <= '0;
      tready_q     <= 1'b0;
      cur_len_q    <= '0;
      first_user_q <= '0;
      pkt_count_q  <= '0;
      beat_count_q <= '0;
      byte_count_q <= '0;
      last_len_q   <= '0;
      last_user_q  <= '0;
      pkt_done_q   <= 1'b0;
      err_keep_q   <= 1'b0;
      err_len_q    <= 1'b0;
      err_user_q   <= 1'b0;
    end else begin
      ctr_q      <= ctr_q + 4'd1;
      tready_q   <= (ctr_q >= throttle);
      pkt_done_q <= accept & s_axis_tlast;

      if (accept) begin
        cur_len_q <= len_d;
        if (state_q == IDLE) first_user_q <= s_axis_tuser;
        state_q <= s_axis_tlast ? IDLE : IN_PKT;
        if (s_axis_tlast) begin
          last_len_q  <= len_d;
          last_user_q <= (state_q == IDLE) ? s_axis_tuser : first_user_q;
        end
      end

      // Clearing wins over a beat accepted in the same cycle.
      if (clr_stats) begin
        pkt_count_q  <= '0;
        beat_count_q <= '0;
        byte_count_q <= '0;
        err_keep_q   <= 1'b0;
        err_len_q    <= 1'b0;
        err_user_q   <= 1'b0;
      end else if (accept) begin
        beat_count_q <= beat_count_q + CNT_W'(1);
        byte_count_q <= byte_count_q + 48'(pop_d);
        if (s_axis_tlast) pkt_count_q <= pkt_count_q + CNT_W'(1);
        err_keep_q <= err_keep_q | keep_bad;
        err_len_q  <= err_len_q  | len_bad;
        err_user_q <= err_user_q | user_bad;
      end
    end
  end

  assign s_axis_tready = tready_q;
  assign pkt_count     = pkt_count_q;
  assign beat_count    = beat_count_q;
  assign byte_count    = byte_count_q;
  assign last_pkt_len  = last_len_q;
  assign last_pkt_user = last_user_q;
  assign pkt_done      = pkt_done_q;
  assign in_packet     = (state_q == IN_PKT);
  assign err_keep      = err_keep_q;
  assign err_len       = err_len_q;
  assign err_user      = err_user_q;

endmodule

// File: tb/tb_axis_packet_sink.sv
// Self-checking bench for axis_packet_sink: completed packets are checked
// against a scoreboard filled as beats are accepted.
module tb_axis_packet_sink;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [511:0] s_axis_tdata = '0;
  logic [63:0]  s_axis_tkeep = '0;
  logic         s_axis_tlast = 1'b0;
  logic [63:0]  s_axis_tuser = '0;
  logic [3:0]   throttle = '0;
  logic         clr_stats = 1'b0;
  logic [31:0]  pkt_count, beat_count;
  logic [47:0]  byte_count;
  logic [15:0]  last_pkt_len;
  logic [63:0]  last_pkt_user;
  logic         pkt_done, in_packet, err_keep, err_len, err_user;

  localparam logic [63:0] FULL = '1;

  axis_packet_sink #(.MAX_PKT_BYTES(9216), .CNT_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .throttle(throttle), .clr_stats(clr_stats),
    .pkt_count(pkt_count), .beat_count(beat_count), .byte_count(byte_count),
    .last_pkt_len(last_pkt_len), .last_pkt_user(last_pkt_user),
    .pkt_done(pkt_done), .in_packet(in_packet),
    .err_keep(err_keep), .err_len(err_len), .err_user(err_user)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] len;
    logic [63:0] user;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_pkts = '0, m_beats = '0;
  logic [47:0] m_bytes = '0;
  logic        m_ek = 1'b0, m_el = 1'b0, m_eu = 1'b0, m_in = 1'b0;
  int          m_len = 0;
  logic [63:0] m_user = '0;

  task automatic model_reset();
    m_pkts = '0; m_beats = '0; m_bytes = '0;
    m_ek = 1'b0; m_el = 1'b0; m_eu = 1'b0; m_in = 1'b0; m_len = 0;
  endtask

  task automatic model_beat(input logic [63:0] keep, input logic last,
                            input logic [63:0] user, input logic clr);
    int n;
    int len;
    n = $countones(keep);
    len = (m_in ? m_len : 0) + n;
    if (len > 65535) len = 65535;
    if (clr) begin
      m_pkts = '0; m_beats = '0; m_bytes = '0;
      m_ek = 1'b0; m_el = 1'b0; m_eu = 1'b0;
    end else begin
      m_beats++;
      m_bytes += 48'(n);
      if (last) m_pkts++;
      if (keep == '0 || (keep & (keep + 64'd1)) != '0 || (!last && keep != FULL)) m_ek = 1'b1;
      if (len > 9216) m_el = 1'b1;
      if (m_in && user != m_user) m_eu = 1'b1;
    end
    if (!m_in) m_user = user;
    if (last) sb.push_back('{16'(len), m_user});
    m_in = !last;
    m_len = len;
  endtask

  // Offer one beat until accepted; returns 1 ns after the accepting edge.
  task automatic send_beat(input logic [63:0] keep, input logic last,
                           input logic [63:0] user, input logic clr);
    int  waited = 0;
    bit  ok = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tdata  = {16{32'($urandom)}};
    clr_stats     = clr;
    while (!ok && waited < 64) begin
      @(negedge aclk);
      if (s_axis_tready === 1'b1) ok = 1;
      else waited++;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL handshake_timeout: tready=%b after %0d cycles, required 1", s_axis_tready, waited);
    end else begin
      @(posedge aclk);
      model_beat(keep, last, user, clr);
      #1;
    end
    s_axis_tvalid = 1'b0;
    clr_stats     = 1'b0;
  endtask

  task automatic do_clr();
    clr_stats = 1'b1;
    @(posedge aclk);
    model_beat(FULL, 1'b1, '0, 1'b1);
    void'(sb.pop_back());
    m_in = 1'b0;
    #1 clr_stats = 1'b0;
  endtask

  // Completed-packet monitor: every pkt_done must match the oldest expectation.
  always @(negedge aclk) begin
    exp_t e;
    if (aresetn && pkt_done) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL pkt_done_unexpected: pulse seen, required none");
      end else begin
        e = sb.pop_front();
        if (last_pkt_len !== e.len || last_pkt_user !== e.user) begin
          miscompares++;
          $display("FAIL pkt_result: len=%0d user=%h, required len=%0d user=%h",
                   last_pkt_len, last_pkt_user, e.len, e.user);
        end
      end
    end
  end

  task automatic test_reset();
    logic [299:0] all_out;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    all_out = {s_axis_tready, pkt_count, beat_count, byte_count, last_pkt_len, last_pkt_user,
               pkt_done, in_packet, err_keep, err_len, err_user};
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: %h, required 0", all_out);
    end
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    vectors++;
    if (s_axis_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: %b, required 1", s_axis_tready);
    end
  endtask

  task automatic test_basic_packet();
    send_beat(FULL, 1'b0, 64'h5, 1'b0);
    vectors++;
    if (in_packet !== 1'b1) begin
      miscompares++; $display("FAIL basic_in_packet: %b, required 1", in_packet);
    end
    send_beat(FULL, 1'b0, 64'h5, 1'b0);
    send_beat(FULL, 1'b0, 64'h5, 1'b0);
    send_beat(64'h0000_0000_0000_FFFF, 1'b1, 64'h5, 1'b0);
    vectors++;
    if (pkt_done !== 1'b1 || last_pkt_len !== 16'd208 || last_pkt_user !== 64'h5) begin
      miscompares++;
      $display("FAIL basic_result: done=%b len=%0d user=%h, required 1/208/5", pkt_done, last_pkt_len, last_pkt_user);
    end
    vectors++;
    if (pkt_count !== 32'd1 || beat_count !== 32'd4 || byte_count !== 48'd208) begin
      miscompares++;
      $display("FAIL basic_counts: pkts=%0d beats=%0d bytes=%0d, required 1/4/208", pkt_count, beat_count, byte_count);
    end
    vectors++;
    if ({err_keep, err_len, err_user, in_packet} !== 4'b0) begin
      miscompares++;
      $display("FAIL basic_flags: %b, required 0000", {err_keep, err_len, err_user, in_packet});
    end
    @(posedge aclk); #1;
    vectors++;
    if (pkt_done !== 1'b0) begin
      miscompares++; $display("FAIL basic_done_pulse: %b, required 0", pkt_done);
    end
  endtask

  task automatic throttle_window(input logic [3:0] thr, input int cycles, input int exp_beats);
    int accepted = 0;
    logic acc;
    throttle = thr;
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b1; s_axis_tkeep = FULL; s_axis_tlast = 1'b1; s_axis_tuser = 64'hC0 + 64'(thr);
    repeat (cycles) begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk);
      if (acc === 1'b1) begin
        accepted++;
        model_beat(FULL, 1'b1, s_axis_tuser, 1'b0);
      end
      #1;
    end
    s_axis_tvalid = 1'b0;
    vectors++;
    if (accepted != exp_beats) begin
      miscompares++;
      $display("FAIL throttle_%0d_rate: %0d beats in %0d cycles, required %0d", thr, accepted, cycles, exp_beats);
    end
    vectors++;
    if (beat_count !== m_beats || byte_count !== m_bytes || pkt_count !== m_pkts) begin
      miscompares++;
      $display("FAIL throttle_%0d_counts: beats=%0d bytes=%0d pkts=%0d, required %0d/%0d/%0d",
               thr, beat_count, byte_count, pkt_count, m_beats, m_bytes, m_pkts);
    end
  endtask

  task automatic test_throttle();
    throttle_window(4'd12, 64, 16);
    throttle_window(4'd15, 32, 2);
    throttle = 4'd0;
    @(posedge aclk); #1;
  endtask

  task automatic test_single_beat();
    send_beat(64'h00FF, 1'b1, 64'hAB, 1'b0);
    vectors++;
    if (in_packet !== 1'b0 || last_pkt_len !== 16'd8 || last_pkt_user !== 64'hAB) begin
      miscompares++;
      $display("FAIL single_beat: in_pkt=%b len=%0d user=%h, required 0/8/ab", in_packet, last_pkt_len, last_pkt_user);
    end
  endtask

  task automatic test_errors();
    do_clr();
    send_beat(64'h0F0F, 1'b1, 64'h3, 1'b0);
    vectors++;
    if ({err_keep, err_len, err_user} !== 3'b100) begin
      miscompares++; $display("FAIL err_keep: flags=%b, required 100", {err_keep, err_len, err_user});
    end
    do_clr();
    send_beat(FULL, 1'b0, 64'h1, 1'b0);
    send_beat(FULL, 1'b1, 64'h2, 1'b0);
    vectors++;
    if ({err_keep, err_len, err_user} !== 3'b001) begin
      miscompares++; $display("FAIL err_user: flags=%b, required 001", {err_keep, err_len, err_user});
    end
    do_clr();
    for (int i = 0; i < 145; i++) begin
      send_beat(FULL, (i == 144), 64'h9, 1'b0);
      if (i == 143) begin
        vectors++;
        if (err_len !== 1'b0) begin
          miscompares++; $display("FAIL err_len_early: %b at 9216 B, required 0", err_len);
        end
      end
    end
    vectors++;
    if (err_len !== 1'b1 || last_pkt_len !== 16'd9280 || err_keep !== 1'b0 || err_user !== 1'b0) begin
      miscompares++;
      $display("FAIL err_len: len_err=%b len=%0d keep=%b user=%b, required 1/9280/0/0",
               err_len, last_pkt_len, err_keep, err_user);
    end
    vectors++;
    if (pkt_count !== m_pkts || beat_count !== m_beats || byte_count !== m_bytes) begin
      miscompares++;
      $display("FAIL err_counts: %0d/%0d/%0d, required %0d/%0d/%0d",
               pkt_count, beat_count, byte_count, m_pkts, m_beats, m_bytes);
    end
  endtask

  task automatic test_clr_on_last();
    send_beat(FULL, 1'b0, 64'h7, 1'b0);
    send_beat(64'hFFFF, 1'b1, 64'h7, 1'b1);
    vectors++;
    if (pkt_count !== '0 || beat_count !== '0 || byte_count !== '0 ||
        {err_keep, err_len, err_user} !== 3'b000) begin
      miscompares++;
      $display("FAIL clr_stats: pkts=%0d beats=%0d bytes=%0d errs=%b, required all 0",
               pkt_count, beat_count, byte_count, {err_keep, err_len, err_user});
    end
    vectors++;
    if (pkt_done !== 1'b1 || last_pkt_len !== 16'd80) begin
      miscompares++;
      $display("FAIL clr_done: done=%b len=%0d, required 1/80", pkt_done, last_pkt_len);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [299:0] all_out;
    send_beat(FULL, 1'b0, 64'h11, 1'b0);
    send_beat(FULL, 1'b0, 64'h11, 1'b0);
    #2 aresetn = 1'b0;
    #1;
    model_reset();
    all_out = {s_axis_tready, pkt_count, beat_count, byte_count, last_pkt_len, last_pkt_user,
               pkt_done, in_packet, err_keep, err_len, err_user};
    vectors++;
    if (all_out !== '0) begin
      miscompares++; $display("FAIL async_reset_outputs: %h, required 0", all_out);
    end
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    send_beat(FULL, 1'b1, 64'h22, 1'b0);
    vectors++;
    if (pkt_count !== 32'd1 || beat_count !== 32'd1 || byte_count !== 48'd64 || last_pkt_len !== 16'd64 ||
        {err_keep, err_len, err_user, in_packet} !== 4'b0) begin
      miscompares++;
      $display("FAIL after_reset_pkt: pkts=%0d beats=%0d bytes=%0d len=%0d flags=%b, required 1/1/64/64/0000",
               pkt_count, beat_count, byte_count, last_pkt_len, {err_keep, err_len, err_user, in_packet});
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_throttle();
    test_single_beat();
    test_errors();
    test_clr_on_last();
    test_reset_mid_packet();
    repeat (3) @(posedge aclk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: %0d packets outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_packet_sink.md
Name: axis_packet_sink

Overview:
- AXI4-Stream slave endpoint: the receiving end of a 512-bit master stream (keep/last/user).
- Accepts packets under a programmable backpressure pattern and tracks packet framing.
- Keeps packet, beat and byte statistics, latches per-packet length and tuser, and raises sticky protocol-error flags.
- Terminates unused or debug stream ports in the middleware and serves as a test sink for stream sources.

Parameters:
- MAX_PKT_BYTES, 9216: largest legal packet, in bytes; anything longer is a length error.
- CNT_W, 32: width of the packet and beat counters.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready (registered)
- s_axis_tdata  in  512  data (ignored apart from handshake)
- s_axis_tkeep  in  64  byte enables
- s_axis_tlast  in  1  end of packet
- s_axis_tuser  in  64  per-packet sideband (destination/flags)
- throttle  in  4  backpressure level: 0 = always ready, 15 = ready 1 cycle in 16
- clr_stats  in  1  synchronous clear of counters and error flags
- pkt_count  out  CNT_W  packets completed
- beat_count  out  CNT_W  beats accepted
- byte_count  out  48  bytes accepted
- last_pkt_len  out  16  byte length of the most recent packet
- last_pkt_user  out  64  tuser of the most recent packet's first beat
- pkt_done  out  1  one-cycle pulse when a packet completes
- in_packet  out  1  high between the first beat and the tlast beat
- err_keep  out  1  sticky tkeep-format error
- err_len  out  1  sticky oversize-packet error
- err_user  out  1  sticky mid-packet tuser-change error

Behaviour:
- Reset: while aresetn is low, all outputs are 0 and the FSM is in IDLE, asynchronously.
- Beat: a beat is accepted when s_axis_tvalid & s_axis_tready at a rising edge of aclk; pop = popcount(tkeep), range 0..64.
- Throttle:
  - A 4-bit free-running counter ctr wraps 15->0.
  - Each edge, s_axis_tready <= (ctr >= throttle).
  - A throttle change takes effect one cycle later.
  - tready does not depend on tvalid.
- FSM, two states:
  - IDLE --accepted beat, tlast=0--> IN_PKT. This captures first_user = tuser and cur_len = pop.
  - IDLE --accepted beat, tlast=1--> IDLE. This is a single-beat packet.
  - IN_PKT --accepted beat, tlast=0--> IN_PKT, with cur_len += pop.
  - IN_PKT --accepted beat, tlast=1--> IDLE.
  - in_packet = (state == IN_PKT).
- Packet completion (the cycle after the tlast beat):
  - last_pkt_len = cur_len + pop, saturating at 16'hFFFF.
  - last_pkt_user = first_user, or the tlast beat's tuser for a single-beat packet.
  - pkt_done = 1 for exactly one cycle.
  - pkt_count += 1.
- Running counters: every accepted beat does beat_count += 1 and byte_count += pop. All counters wrap modulo 2^width.
- err_keep is set if any of these holds:
  - tkeep == 0 on a beat;
  - tkeep is not contiguous from bit 0 (i.e. tkeep & (tkeep+1) != 0);
  - a non-last beat has tkeep != all-ones.
- err_len is set when the running length exceeds MAX_PKT_BYTES. It is detected on the beat that crosses the limit; the packet is still consumed to tlast.
- err_user is set when an IN_PKT beat has tuser != first_user.
- All error flags hold until clr_stats or reset.
- clr_stats:
  - Zeroes pkt_count, beat_count, byte_count and the err_* flags next cycle.
  - It takes precedence over a beat accepted in the same cycle; that beat is not counted, and its errors are not flagged.
  - FSM state, cur_len, first_user, last_pkt_* and pkt_done still update normally.
- Reset mid-packet: FSM returns to IDLE. The next accepted beat starts a new packet; no error is flagged.
- tvalid dropping mid-packet is legal; state holds.

Test Plan:
- Reset with throttle=0, then 4-beat packet: 3 beats tkeep=all-ones, last beat tkeep=64'h0000_0000_0000_FFFF, tuser=0x5 → last_pkt_len=208, last_pkt_user=5, pkt_count=1, beat_count=4, byte_count=208, single pkt_done pulse, no errors.
- throttle=12, tvalid held high for 64 cycles → tready high 4 of every 16 cycles, beat_count=16; throttle=15 → 1 beat per 16 cycles.
- Single-beat packet, tkeep=64'h00FF, tlast=1, tuser=0xAB → in_packet stays 0, last_pkt_len=8, last_pkt_user=0xAB.
- Illegal beats:
  - tkeep=64'h0F0F → err_keep=1.
  - New packet with tuser 0x1 then 0x2 mid-packet → err_user=1.
  - 145 full beats (9280 B) → err_len=1 on beat 145; last_pkt_len=9280.
- clr_stats asserted on the cycle a tlast beat is accepted → pkt_count/beat_count/byte_count=0, err_*=0, pkt_done still pulses, last_pkt_len updated.
- aresetn pulsed low after 2 beats of a packet → all outputs 0 asynchronously; a following 1-beat packet gives pkt_count=1 and no errors.
